pc_fetch_ctrl: RTL and testbench

- Drives the write side of the PC register: generates pcreg's `in`/`ena` and consumes its `out`.
- Fetches each instruction at the current PC over a req/ack instruction-memory port.
- Presents the fetched instruction downstream with a valid/ready handshake.
- Sequences PC+4 advance, branch/jump redirects and discard of in-flight fetches; sits between pcreg, imem and decode.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/pc_fetch_ctrl_if.sv | 34 +++
 rtl/fetch_wdog.sv | 50 +++++
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the PC fetch controller.
//   - word_t      : 32-bit machine word (PCs and instructions)
//   - state_t     : 2-bit FSM state type, with S_IDLE/S_REQ/S_HOLD/S_UPD encodings
//   - INST_BYTES_DFLT / MAX_WAIT_DFLT : default parameter values
//   - pc_advance  : wrapping PC adder
package fetch_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_HOLD = 2'd2;
  localparam state_t S_UPD  = 2'd3;

  localparam int unsigned INST_BYTES_DFLT = 32'd4;
  localparam int unsigned MAX_WAIT_DFLT   = 32'd15;

  // PC increment; the 32-bit add deliberately wraps mod 2^32.
  function automatic word_t pc_advance(input word_t pc, input word_t inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: bundle of every non-clock/reset signal of pc_fetch_ctrl.
//   pcreg side : pc_cur (in), pc_next/pc_ena (out)
//   imem side  : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//   decode side: inst_valid/inst/inst_pc (out), inst_ready (in)
//   control    : redirect/redirect_pc (in), fetch_err (out)
// master = the fetch controller, slave = its environment.
import fetch_pkg::*;

interface pc_fetch_ctrl_if;
  word_t pc_cur;
  word_t pc_next;
  logic  pc_ena;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;
  logic  inst_valid;
  word_t inst;
  word_t inst_pc;
  logic  inst_ready;
  logic  redirect;
  word_t redirect_pc;
  logic  fetch_err;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, inst_ready, redirect, redirect_pc,
    output pc_next, pc_ena, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, inst_ready, redirect, redirect_pc,
    input  pc_next, pc_ena, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err
  );
endinterface

// File: rtl/fetch_wdog.sv
// fetch_wdog: 8-bit imem wait counter with a sticky expiry flag.
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   count_en : one more cycle spent waiting for ack
//   clear    : ack seen, restart the count (wins over count_en)
//   expired  : sticky, set once the count reaches MAX_WAIT
module fetch_wdog #(
  parameter int unsigned MAX_WAIT = 32'd15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       expired_q;
  logic       expired_d;

  // Next count (saturating so a long stall never wraps back through LIMIT) and sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (count_en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    expired_d = expired_q | (cnt_d == LIMIT);
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 8'd0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequences instruction fetch between pcreg, imem and decode.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : pc_fetch_ctrl_if.master
//           pc_cur -> pc_next/pc_ena   (pcreg write port, Mealy pulse)
//           imem_req/imem_addr <- imem_ack/imem_rdata
//           inst_valid/inst/inst_pc <- inst_ready
//           redirect/redirect_pc (branch/jump), fetch_err (sticky timeout)
// Flow: IDLE -> REQ -> HOLD -> UPD -> REQ ... ; a redirect rewrites the PC at
// once and any fetch already on the wire is dropped when its ack arrives.
import fetch_pkg::*;

module pc_fetch_ctrl #(
  parameter int unsigned INST_BYTES = INST_BYTES_DFLT,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DFLT
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_ctrl_if.master bus
);

  localparam word_t INST_INC = word_t'(INST_BYTES);

  state_t state_q;
  state_t state_d;
  logic   drop_q;
  logic   drop_d;
  word_t  imem_addr_q;
  word_t  imem_addr_d;
  word_t  inst_q;
  word_t  inst_d;
  word_t  inst_pc_q;
  word_t  inst_pc_d;

  logic   pc_ena_s;
  word_t  pc_next_s;
  logic   wd_count_en;
  logic   wd_clear;
  logic   wd_expired;

  // PC write port: a redirect always wins over the sequential advance.
  always_comb begin
    pc_ena_s  = 1'b0;
    pc_next_s = 32'd0;
    if (bus.redirect) begin
      pc_ena_s  = 1'b1;
      pc_next_s = bus.redirect_pc;
    end else if ((state_q == S_HOLD) && bus.inst_ready) begin
      pc_ena_s  = 1'b1;
      pc_next_s = pc_advance(inst_pc_q, INST_INC);
    end else begin
      pc_ena_s  = 1'b0;
      pc_next_s = 32'd0;
    end
  end

  // FSM next state, fetch bookkeeping and watchdog controls.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    imem_addr_d = imem_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    wd_count_en = 1'b0;
    wd_clear    = 1'b0;
    case (state_q)
      S_IDLE, S_UPD: begin
        // pc_cur is only trustworthy for the new fetch once no write is pending.
        if (bus.redirect) begin
          state_d = S_UPD;
        end else begin
          state_d     = S_REQ;
          imem_addr_d = bus.pc_cur;
        end
      end
      S_REQ: begin
        if (bus.imem_ack) begin
          wd_clear = 1'b1;
          drop_d   = 1'b0;
          if (bus.redirect) begin
            state_d = S_UPD;
          end else if (drop_q) begin
            // Stale data from before a redirect: refetch from the updated PC.
            state_d     = S_REQ;
            imem_addr_d = bus.pc_cur;
          end else begin
            state_d   = S_HOLD;
            inst_d    = bus.imem_rdata;
            inst_pc_d = imem_addr_q;
          end
        end else begin
          // The request stays up; a redirect only marks the eventual data stale.
          wd_count_en = 1'b1;
          if (bus.redirect) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end
      end
      S_HOLD: begin
        if (bus.redirect || bus.inst_ready) begin
          state_d = S_UPD;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      drop_q      <= 1'b0;
      imem_addr_q <= 32'd0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      imem_addr_q <= imem_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  fetch_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (wd_count_en),
    .clear    (wd_clear),
    .expired  (wd_expired)
  );

  // Strobes are gated by reset so nothing leaks out before the first reset edge.
  assign bus.pc_ena     = reset & pc_ena_s;
  assign bus.pc_next    = reset ? pc_next_s : 32'd0;
  assign bus.imem_req   = reset & (state_q == S_REQ);
  assign bus.inst_valid = reset & (state_q == S_HOLD);
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fetch_err  = wd_expired;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed + random bench for pc_fetch_ctrl against a
// transaction-level model (fetch outstanding / buffer full / bubble cycle)
// plus a behavioural pcreg that feeds pc_cur back.
module tb_pc_fetch_ctrl;
  import fetch_pkg::*;

  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.INST_BYTES(4), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bubble cycle pending, fetch outstanding (and whether its data is stale),
  // buffered instruction, wait count, sticky error, and the pcreg contents.
  bit          m_bubble = 1'b0;
  bit          m_req    = 1'b0;
  bit          m_stale  = 1'b0;
  bit          m_full   = 1'b0;
  bit          m_err    = 1'b0;
  int          m_wait   = 0;
  logic [31:0] m_addr   = 32'd0;
  logic [31:0] m_inst   = 32'd0;
  logic [31:0] m_ipc    = 32'd0;
  logic [31:0] pc_reg   = 32'd0;

  // Values sampled from the DUT in the current cycle.
  logic        s_req, s_valid, s_ena, s_err;
  logic [31:0] s_addr, s_inst, s_ipc, s_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample, compare with the model, advance the model.
  task automatic cycle(input bit rst_n, input bit ack, input logic [31:0] rdata,
                       input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          e_ena;
    logic [31:0] e_next;
    logic [31:0] cur;
    @(negedge clk);
    cur             = pc_reg;
    reset           = rst_n;
    bus.pc_cur      = cur;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    s_req = bus.imem_req;  s_valid = bus.inst_valid; s_ena = bus.pc_ena; s_err = bus.fetch_err;
    s_addr = bus.imem_addr; s_inst = bus.inst; s_ipc = bus.inst_pc; s_next = bus.pc_next;

    e_ena  = rst_n && (redir || (m_full && rdy));
    e_next = !e_ena ? 32'd0 : (redir ? rpc : m_ipc + 32'd4);
    chk1("imem_req", s_req, rst_n && m_req);
    chk1("inst_valid", s_valid, rst_n && m_full);
    chk1("pc_ena", s_ena, e_ena);
    if (e_ena || !rst_n) chk("pc_next", s_next, e_next);
    if (rst_n && m_req) chk("imem_addr", s_addr, m_addr);
    if (rst_n && m_full) begin
      chk("inst", s_inst, m_inst);
      chk("inst_pc", s_ipc, m_ipc);
    end
    if (rst_n) chk1("fetch_err", s_err, m_err);

    if (e_ena) pc_reg = e_next;
    if (!rst_n) begin
      m_bubble = 1'b1; m_req = 1'b0; m_stale = 1'b0; m_full = 1'b0;
      m_err = 1'b0; m_wait = 0;
    end else if (m_bubble) begin
      if (!redir) begin
        m_bubble = 1'b0; m_req = 1'b1; m_addr = cur;
      end
    end else if (m_req) begin
      if (ack) begin
        m_wait = 0;
        if (redir) begin
          m_req = 1'b0; m_stale = 1'b0; m_bubble = 1'b1;
        end else if (m_stale) begin
          m_stale = 1'b0; m_addr = cur;
        end else begin
          m_req = 1'b0; m_full = 1'b1; m_inst = rdata; m_ipc = m_addr;
        end
      end else begin
        if (m_wait < 255) m_wait++;
        if (m_wait == MAXW) m_err = 1'b1;
        if (redir) m_stale = 1'b1;
      end
    end else if (m_full) begin
      if (redir || rdy) begin
        m_full = 1'b0; m_bubble = 1'b1;
      end
    end
  endtask

  initial begin
    bus.pc_cur = 32'd0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // 1: basic fetch from PC 0
    cycle(1, 0, 0, 0, 0, 0);
    chk1("idle_no_req", s_req, 1'b0);
    chk("rst_inst", s_inst, 32'd0); chk("rst_inst_pc", s_ipc, 32'd0); chk("rst_addr", s_addr, 32'd0);
    cycle(1, 1, 32'h11111111, 0, 0, 0);
    chk1("t1_req", s_req, 1'b1); chk("t1_addr", s_addr, 32'h0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("t1_inst", s_inst, 32'h11111111); chk("t1_ipc", s_ipc, 32'h0);
    chk1("t1_ena", s_ena, 1'b1); chk("t1_next", s_next, 32'h4);
    cycle(1, 0, 0, 0, 0, 0);
    chk1("t1_upd_req", s_req, 1'b0);
    // 2: backpressure
    cycle(1, 1, 32'h22222222, 0, 0, 0);
    chk("t2_addr", s_addr, 32'h4);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk1("t2_valid", s_valid, 1'b1); chk("t2_inst", s_inst, 32'h22222222);
      chk("t2_ipc", s_ipc, 32'h4); chk1("t2_no_ena", s_ena, 1'b0);
    end
    cycle(1, 0, 0, 1, 0, 0);
    chk1("t2_ena", s_ena, 1'b1); chk("t2_next", s_next, 32'h8);
    cycle(1, 0, 0, 0, 0, 0);
    // 4: redirect coincident with handshake at inst_pc 8
    cycle(1, 1, 32'h33333333, 0, 0, 0);
    chk("t4_addr", s_addr, 32'h8);
    cycle(1, 0, 0, 1, 1, 32'h40);
    chk("t4_ipc", s_ipc, 32'h8); chk("t4_next", s_next, 32'h40);
    cycle(1, 0, 0, 0, 0, 0);
    chk1("t4_valid_gone", s_valid, 1'b0);
    // 3: redirect while a fetch is outstanding, late ack discarded
    cycle(1, 0, 0, 0, 1, 32'h100);
    chk("t3_addr_old", s_addr, 32'h40); chk1("t3_ena", s_ena, 1'b1); chk("t3_next", s_next, 32'h100);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk1("t3_req_held", s_req, 1'b1);
    cycle(1, 1, 32'h0000DEAD, 0, 0, 0);
    cycle(1, 1, 32'h44444444, 0, 0, 0);
    chk("t3_addr_new", s_addr, 32'h100); chk1("t3_no_valid", s_valid, 1'b0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("t3_inst", s_inst, 32'h44444444); chk("t3_next", s_next, 32'h104);
    cycle(1, 0, 0, 0, 0, 0);
    // 5: timeout
    for (int i = 1; i <= 20; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk1("t5_err", s_err, (i >= 16));
      chk1("t5_req", s_req, 1'b1);
    end
    cycle(1, 1, 32'h55555555, 0, 0, 0);
    chk1("t5_err_ack", s_err, 1'b1);
    // 6: wrap and mid-fetch reset
    cycle(1, 0, 0, 1, 1, 32'hFFFFFFFC);
    chk("t6_next_redir", s_next, 32'hFFFFFFFC); chk1("t6_err_sticky", s_err, 1'b1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h66666666, 0, 0, 0);
    chk("t6_addr", s_addr, 32'hFFFFFFFC);
    cycle(1, 0, 0, 1, 0, 0);
    chk("t6_ipc", s_ipc, 32'hFFFFFFFC); chk1("t6_ena", s_ena, 1'b1); chk("t6_wrap", s_next, 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk1("t6_req", s_req, 1'b1); chk("t6_addr0", s_addr, 32'h0);
    cycle(0, 1, 32'h77777777, 0, 0, 0);
    chk1("t6_rst_req", s_req, 1'b0);
    cycle(1, 0, 0, 0, 0, 0);
    chk1("t6_idle_req", s_req, 1'b0); chk1("t6_err_clr", s_err, 1'b0);
    cycle(1, 1, 32'h88888888, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("t6_inst", s_inst, 32'h88888888);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bit rst_n, ack, rdy, redir;
      rst_n = ($urandom_range(0, 299) != 0);
      ack   = m_req && ($urandom_range(0, 99) < ((n % 500) < 60 ? 2 : 45));
      rdy   = ($urandom_range(0, 99) < 60);
      redir = ($urandom_range(0, 99) < 6);
      cycle(rst_n, ack, $urandom(), rdy, redir, $urandom() & 32'hFFFFFFFC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
